// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car elevator controller with call latching, direction
// preference, timed travel/door phases and an absorbing emergency stop.
module elevator_ctrl #(
    parameter int NUM_FLOORS    = 3,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  emerg_in,
    input  logic [NUM_FLOORS-1:0] floor_req,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    prev_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  emerg_out
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MOVE_UP   = 3'd1;
    localparam logic [2:0] S_MOVE_DOWN = 3'd2;
    localparam logic [2:0] S_DOOR_OPEN = 3'd3;
    localparam logic [2:0] S_EMERG     = 3'd4;

    logic [2:0]            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [FLOOR_W-1:0]    cur_n, prev_n, nxt_floor;
    logic [NUM_FLOORS-1:0] pending_n, req_eff, clr_mask;
    logic                  last_up, last_up_n;
    logic                  emerg_n;
    logic                  here, above, below;

    // One-hot vector selecting floor f
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        floor_bit = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) == f) floor_bit[i] = 1'b1;
    endfunction

    // Any call strictly above floor f
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) > f && v[i]) any_above = 1'b1;
    endfunction

    // Any call strictly below floor f
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (FLOOR_W'(i) < f && v[i]) any_below = 1'b1;
    endfunction

    // Next-state logic; emergency overrides everything computed below it
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cur_n     = cur_floor;
        prev_n    = prev_floor;
        last_up_n = last_up;
        emerg_n   = emerg_out;
        req_eff   = floor_req;
        clr_mask  = '0;
        nxt_floor = cur_floor;
        here      = |(pending & floor_bit(cur_floor));
        above     = any_above(pending, cur_floor);
        below     = any_below(pending, cur_floor);

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (here) begin
                    state_n  = S_DOOR_OPEN;
                    clr_mask = floor_bit(cur_floor);
                end else if (above && (last_up || !below)) begin
                    state_n   = S_MOVE_UP;
                    last_up_n = 1'b1;
                end else if (below) begin
                    state_n   = S_MOVE_DOWN;
                    last_up_n = 1'b0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (cnt == TRAVEL_LAST) begin
                    nxt_floor = (state == S_MOVE_UP) ? cur_floor + FLOOR_W'(1)
                                                     : cur_floor - FLOOR_W'(1);
                    cur_n  = nxt_floor;
                    prev_n = cur_floor;
                    cnt_n  = '0;
                    // Decide on the floor just reached, not the one left
                    if (|(pending & floor_bit(nxt_floor))) begin
                        state_n  = S_DOOR_OPEN;
                        clr_mask = floor_bit(nxt_floor);
                    end else if (state == S_MOVE_UP ? any_above(pending, nxt_floor)
                                                    : any_below(pending, nxt_floor)) begin
                        state_n   = state;
                        last_up_n = (state == S_MOVE_UP);
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DOOR_OPEN: begin
                // A call for the floor being served is already satisfied
                req_eff = floor_req & ~floor_bit(cur_floor);
                if (cnt == DOOR_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = S_EMERG;
        endcase

        pending_n = (pending | req_eff) & ~clr_mask;

        if (emerg_in || state == S_EMERG) begin
            state_n   = S_EMERG;
            emerg_n   = 1'b1;
            pending_n = '0;
            cnt_n     = '0;
            cur_n     = cur_floor;
            prev_n    = prev_floor;
            last_up_n = last_up;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cur_floor  <= '0;
            prev_floor <= '0;
            pending    <= '0;
            last_up    <= 1'b1;
            emerg_out  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cur_floor  <= cur_n;
            prev_floor <= prev_n;
            pending    <= pending_n;
            last_up    <= last_up_n;
            emerg_out  <= emerg_n;
        end
    end

    assign moving_up   = (state == S_MOVE_UP);
    assign moving_down = (state == S_MOVE_DOWN);
    assign door_open   = (state == S_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed scenarios plus random calls, checked cycle by
// cycle against a behavioural model through an expected-output queue.
module tb_elevator_ctrl;

    localparam int NF = 4;
    localparam int FW = 4;
    localparam int TC = 4;
    localparam int DC = 3;

    localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DOOR = 3, M_EM = 4;

    typedef struct packed {
        logic [FW-1:0] cur;
        logic [FW-1:0] prev;
        logic [NF-1:0] pend;
        logic          up;
        logic          dn;
        logic          door;
        logic          em;
    } obs_t;

    logic          clk;
    logic          reset;
    logic          emerg_in;
    logic [NF-1:0] floor_req;
    logic [FW-1:0] cur_floor, prev_floor;
    logic [NF-1:0] pending;
    logic          moving_up, moving_down, door_open, emerg_out;

    elevator_ctrl #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .emerg_in(emerg_in), .floor_req(floor_req),
        .cur_floor(cur_floor), .prev_floor(prev_floor), .pending(pending),
        .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open), .emerg_out(emerg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    obs_t sb_q[$];

    // Behavioural model state
    int      m_floor, m_prev, m_mode, m_left;
    bit      m_pref_up, m_em;
    bit [3:0] m_pend;

    // Directed-scenario observations taken from the DUT at negedges
    obs_t seen;
    int   door_cnt, move_cnt;
    bit   last_door;
    int   door_floors[$];

    function automatic obs_t sample();
        obs_t o;
        o.cur  = cur_floor;   o.prev = prev_floor; o.pend = pending;
        o.up   = moving_up;   o.dn   = moving_down;
        o.door = door_open;   o.em   = emerg_out;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.cur  = FW'(m_floor); o.prev = FW'(m_prev); o.pend = m_pend;
        o.up   = (m_mode == M_UP); o.dn = (m_mode == M_DN);
        o.door = (m_mode == M_DOOR); o.em = m_em;
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Any call in floors lo..hi inclusive (empty range -> none)
    function automatic bit m_any(input bit [3:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (i >= 0 && i < NF && v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_prev = 0; m_mode = M_IDLE; m_left = 0;
        m_pref_up = 1'b1; m_em = 1'b0; m_pend = '0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge
    task automatic model_step(input bit [3:0] req, input bit em);
        bit [3:0] old = m_pend;
        bit [3:0] add = req;
        int       clr = -1;
        if (m_em || em) begin
            m_em = 1'b1; m_mode = M_EM; m_pend = '0; m_left = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (old[m_floor]) begin
                    m_mode = M_DOOR; m_left = DC; clr = m_floor;
                end else if (m_any(old, m_floor + 1, NF - 1) &&
                             (m_pref_up || !m_any(old, 0, m_floor - 1))) begin
                    m_mode = M_UP; m_left = TC; m_pref_up = 1'b1;
                end else if (m_any(old, 0, m_floor - 1)) begin
                    m_mode = M_DN; m_left = TC; m_pref_up = 1'b0;
                end
            end
            M_UP, M_DN: begin
                m_left--;
                if (m_left == 0) begin
                    m_prev  = m_floor;
                    m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
                    if (old[m_floor]) begin
                        m_mode = M_DOOR; m_left = DC; clr = m_floor;
                    end else if (m_mode == M_UP ? m_any(old, m_floor + 1, NF - 1)
                                                : m_any(old, 0, m_floor - 1)) begin
                        m_left = TC;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_DOOR: begin
                add[m_floor] = 1'b0;
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
            default: ;
        endcase
        m_pend = old | add;
        if (clr >= 0) m_pend[clr] = 1'b0;
    endtask

    task automatic clear_obs();
        door_cnt = 0; move_cnt = 0; last_door = 1'b0; door_floors.delete();
    endtask

    // One cycle: observe DUT, drive inputs, advance model, queue expectation
    task automatic tick(input bit [3:0] req, input bit em);
        @(negedge clk);
        seen = sample();
        if (seen.door) door_cnt++;
        if (seen.up || seen.dn) move_cnt++;
        if (seen.door && !last_door) door_floors.push_back(int'(seen.cur));
        last_door = seen.door;
        floor_req = req;
        emerg_in  = em;
        model_step(req, em);
        sb_q.push_back(model_obs());
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; floor_req = '0; emerg_in = 1'b0;
        sb_q.delete();
        model_reset();
        #1 chk("reset_state", int'(sample()), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_obs();
    endtask

    // Monitor: every post-edge DUT state is compared with the queued model output
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = sample();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL sb cyc=%0d got cur=%0d prev=%0d pend=%b up=%b dn=%b door=%b em=%b expected cur=%0d prev=%0d pend=%b up=%b dn=%b door=%b em=%b",
                             cyc, a.cur, a.prev, a.pend, a.up, a.dn, a.door, a.em,
                             e.cur, e.prev, e.pend, e.up, e.dn, e.door, e.em);
                end
            end
        end
    end

    initial begin
        int budget;
        reset = 1'b1; emerg_in = 1'b0; floor_req = '0;
        model_reset();
        clear_obs();
        reset_dut();

        // Single call to floor 2 from floor 0
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b0);
        chk("req028_pend_latched", int'(seen.pend), 4'b0100);
        repeat (20) tick(4'b0000, 1'b0);
        chk("req028_door_cycles", door_cnt, DC);
        chk("req028_cur", int'(cur_floor), 2);
        chk("req028_prev", int'(prev_floor), 1);
        chk("req028_pend_clear", int'(pending), 0);
        chk("req028_door_floor", (door_floors.size() == 1) ? door_floors[0] : -1, 2);

        // Call at the current floor: door only, no movement
        reset_dut();
        tick(4'b0001, 1'b0);
        repeat (8) tick(4'b0000, 1'b0);
        chk("req029_door_cycles", door_cnt, DC);
        chk("req029_no_move", move_cnt, 0);
        chk("req029_cur", int'(cur_floor), 0);
        chk("req029_pend", int'(pending), 0);

        // Heading up past floor 1 with calls at 3 and 0: serve 3 first
        reset_dut();
        tick(4'b1000, 1'b0);
        budget = 0;
        while (!(m_mode == M_UP && m_floor == 1) && budget < 40) begin
            tick(4'b0000, 1'b0); budget++;
        end
        chk("req030_reach_f1", budget < 40, 1);
        tick(4'b0001, 1'b0);
        budget = 0;
        while (!(m_mode == M_IDLE && m_pend == 0) && budget < 80) begin
            tick(4'b0000, 1'b0); budget++;
        end
        tick(4'b0000, 1'b0);
        chk("req030_settle", budget < 80, 1);
        chk("req030_door_count", door_floors.size(), 2);
        chk("req030_first_stop", (door_floors.size() > 0) ? door_floors[0] : -1, 3);
        chk("req030_second_stop", (door_floors.size() > 1) ? door_floors[1] : -1, 0);

        // Emergency mid-travel out of floor 1 at travel count 2
        reset_dut();
        tick(4'b1000, 1'b0);
        budget = 0;
        while (!(m_mode == M_UP && m_floor == 1 && m_left == TC - 2) && budget < 40) begin
            tick(4'b0000, 1'b0); budget++;
        end
        chk("req031_reach_point", budget < 40, 1);
        tick(4'b0000, 1'b1);
        tick(4'b1111, 1'b0);
        chk("req031_emerg", int'(seen.em), 1);
        chk("req031_cur_hold", int'(seen.cur), 1);
        chk("req031_pend_zero", int'(seen.pend), 0);
        repeat (5) tick(4'b1111, 1'b0);
        tick(4'b0000, 1'b0);
        chk("req031_still_emerg", int'(seen.em), 1);
        chk("req031_req_ignored", int'(seen.pend), 0);

        // Emergency and call in the same cycle
        reset_dut();
        tick(4'b0010, 1'b1);
        tick(4'b0000, 1'b0);
        chk("req032_emerg", int'(seen.em), 1);
        chk("req032_pend", int'(seen.pend), 0);

        // Asynchronous reset in the middle of a door cycle at floor 2
        reset_dut();
        tick(4'b0100, 1'b0);
        budget = 0;
        while (!(m_mode == M_DOOR && m_left == 2) && budget < 40) begin
            tick(4'b0000, 1'b0); budget++;
        end
        chk("req033_reach_door", budget < 40, 1);
        @(posedge clk);
        #2;
        chk("req033_pre_door", int'(door_open), 1);
        reset = 1'b1;
        sb_q.delete();
        model_reset();
        #1 chk("req033_async_clear", int'(sample()), 0);
        reset_dut();

        // Random call traffic with rare emergencies, reset between segments
        for (int seg = 0; seg < 4; seg++) begin
            reset_dut();
            for (int n = 0; n < 400; n++) begin
                bit [3:0] r;
                bit       e;
                r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                e = (seg == 3 && $urandom_range(0, 299) == 0);
                tick(r, e);
            end
        end

        @(posedge clk);
        #2;
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 3, number of served floors (2..16).
REQ-002 Parameter FLOOR_W, default 4, width of floor-number outputs; SHALL satisfy 2^FLOOR_W >= NUM_FLOORS.
REQ-003 Parameter TRAVEL_CYCLES, default 8, clock cycles to move one floor (>=1).
REQ-004 Parameter DOOR_CYCLES, default 4, clock cycles the door stays open (>=1).
REQ-005 clk  input  1  sole clock; all state changes on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 emerg_in  input  1  emergency request, sampled each posedge.
REQ-008 floor_req  input  NUM_FLOORS  per-floor call buttons, bit i = floor i; multiple bits legal.
REQ-009 cur_floor  output  FLOOR_W  registered current floor.
REQ-010 prev_floor  output  FLOOR_W  registered floor last departed.
REQ-011 pending  output  NUM_FLOORS  registered outstanding-call vector.
REQ-012 moving_up / moving_down  output  1 each  high while in MOVE_UP / MOVE_DOWN.
REQ-013 door_open  output  1  high while in DOOR_OPEN.
REQ-014 emerg_out  output  1  sticky emergency flag.

Function
REQ-015 States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERG; all outputs registered, decoded from state and registers.
REQ-016 Each posedge outside EMERG: pending <= pending | floor_req, minus any bit cleared by REQ-020 in the same cycle (clear wins).
REQ-017 IDLE decision, on registered pending: bit cur_floor set -> DOOR_OPEN; else any bit above set and (last_dir = up or none below) -> MOVE_UP; else any bit below set -> MOVE_DOWN; else stay IDLE.
REQ-018 last_dir register, reset = up; updated on every entry to MOVE_UP/MOVE_DOWN.
REQ-019 MOVE_x: travel counter counts 0..TRAVEL_CYCLES-1; on final cycle prev_floor <= cur_floor, cur_floor <= cur_floor +/- 1, counter <= 0, and next state chosen on the new floor: pending bit set -> DOOR_OPEN; else pending further in same direction -> same MOVE_x; else IDLE.
REQ-020 DOOR_OPEN lasts exactly DOOR_CYCLES cycles; pending[cur_floor] cleared on the entry edge; a re-press of cur_floor during DOOR_OPEN is ignored; exit to IDLE.
REQ-021 cur_floor SHALL never exceed NUM_FLOORS-1 nor go below 0; MOVE_UP at top or MOVE_DOWN at floor 0 SHALL not occur.
REQ-022 emerg_in high at any posedge from any state: next state EMERG, emerg_out <= 1, pending <= 0, travel/door counters frozen at 0, cur_floor and prev_floor hold.
REQ-023 EMERG is absorbing: floor_req ignored, moving_up/moving_down/door_open = 0; only reset exits.
REQ-024 emerg_in has priority over floor_req and all timer expiries in the same cycle.
REQ-025 Mid-travel emergency: cur_floor keeps the last reached floor (no partial-floor advance).

Reset
REQ-026 While reset high, asynchronously: state IDLE, cur_floor = 0, prev_floor = 0, pending = 0, emerg_out = 0, counters = 0, last_dir = up, all status outputs 0.
REQ-027 First active edge after reset deassertion processes inputs normally; reset asserted mid-move or mid-door aborts immediately with no residual pending.

Verification (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-028 Reset, one-cycle floor_req=4'b0100 -> pending=4'b0100 next cycle; MOVE_UP; cur_floor 1 after 4 travel cycles, 2 after 8; door_open high exactly 3 cycles; pending=0; IDLE, prev_floor=1.
REQ-029 At floor 0 IDLE, floor_req=4'b0001 -> DOOR_OPEN on next decision, 3 cycles, no movement, pending cleared.
REQ-030 At floor 1 heading up, pending 4'b1001 -> stops at 3 first (door 3 cycles), then MOVE_DOWN to 0; never reverses early.
REQ-031 emerg_in pulse during MOVE_UP from floor 1 at travel count 2 -> emerg_out=1 next edge, cur_floor stays 1, pending=0, later floor_req ignored; held until reset.
REQ-032 emerg_in and floor_req asserted same cycle from IDLE -> EMERG, pending remains 0.
REQ-033 Reset asserted asynchronously mid-DOOR_OPEN at floor 2 -> all outputs 0 without waiting for clk edge.
